// File: rtl/supersonic_pkg.sv
// Shared types and default timing for the ultrasonic sensor responder.
package supersonic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_DONE,
    ST_HOLDOFF
  } state_t;

  localparam int unsigned TRIG_CYCLES_DEF  = 500;
  localparam int unsigned CYC_PER_MM_DEF   = 292;
  localparam int unsigned RISE_TIMEOUT_DEF = 1_000_000;
  localparam int unsigned ECHO_MAX_DEF     = 1_900_000;
  localparam int unsigned HOLDOFF_DEF      = 3_000_000;
  localparam int unsigned DIST_W           = 32;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Phase counter is sized for the longest of the cycle-count parameters.
  localparam int unsigned CNT_W = $clog2(max2(max2(TRIG_CYCLES_DEF, RISE_TIMEOUT_DEF),
                                              max2(ECHO_MAX_DEF, HOLDOFF_DEF)));

endpackage

// File: rtl/supersonic_if_if.sv
// Controller-side request/result handshake of the ultrasonic responder.
interface supersonic_if_if;
  import supersonic_pkg::*;

  logic              trigger;
  logic              triggerSuc;
  logic              valid;
  logic              timeout;
  logic [DIST_W-1:0] distance;

  modport master (output trigger, input triggerSuc, valid, distance, timeout);
  modport slave  (input trigger, output triggerSuc, valid, distance, timeout);

endinterface

// File: rtl/supersonic_if_echo_sync.sv
// Two-flop synchronizer for the sensor ECHO pin plus one-cycle rise/fall pulses.
module supersonic_if_echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic echo,
  output logic rise_c,
  output logic fall_c
);

  // sh[1] is the synchronized level, sh[2] its previous value.
  logic [2:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh <= '0;
    else     sh <= {sh[1:0], echo};
  end

  assign rise_c =  sh[1] & ~sh[2];
  assign fall_c = ~sh[1] &  sh[2];

endmodule

// File: rtl/supersonic_if.sv
// Responder for an HC-SR04-class sensor: issues TRIG, times ECHO, reports range in mm.
module supersonic_if
  import supersonic_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES  = TRIG_CYCLES_DEF,
  parameter int unsigned CYC_PER_MM   = CYC_PER_MM_DEF,
  parameter int unsigned RISE_TIMEOUT = RISE_TIMEOUT_DEF,
  parameter int unsigned ECHO_MAX     = ECHO_MAX_DEF,
  parameter int unsigned HOLDOFF      = HOLDOFF_DEF
) (
  input  logic             clk,
  input  logic             rst,
  supersonic_if_if.slave   bus,
  output logic             trig_pin,
  input  logic             echo_pin
);

  localparam int unsigned PRE_W = (CYC_PER_MM > 1) ? $clog2(CYC_PER_MM) : 1;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [PRE_W-1:0]  pre;
  logic [DIST_W-1:0] mm;
  logic              res_to;
  logic              rise_c;
  logic              fall_c;

  supersonic_if_echo_sync u_echo_sync (
    .clk    (clk),
    .rst    (rst),
    .echo   (echo_pin),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      pre            <= '0;
      mm             <= '0;
      res_to         <= 1'b0;
      trig_pin       <= 1'b0;
      bus.triggerSuc <= 1'b0;
      bus.valid      <= 1'b0;
      bus.timeout    <= 1'b0;
      bus.distance   <= '0;
    end else begin
      bus.triggerSuc <= 1'b0;
      bus.valid      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.trigger) begin
            state          <= ST_TRIG;
            trig_pin       <= 1'b1;
            cnt            <= '0;
            bus.triggerSuc <= (TRIG_CYCLES == 1);
          end
        end
        ST_TRIG: begin
          // Ack lands on the last TRIG-high cycle.
          if (cnt == CNT_W'(TRIG_CYCLES - 1)) begin
            trig_pin <= 1'b0;
            state    <= ST_WAIT_RISE;
            cnt      <= CNT_W'(1);
          end else begin
            cnt            <= cnt + CNT_W'(1);
            bus.triggerSuc <= (cnt == CNT_W'(TRIG_CYCLES - 2));
          end
        end
        ST_WAIT_RISE: begin
          // cnt counts cycles since TRIG fell, including the DONE cycle.
          if (rise_c) begin
            state <= ST_MEASURE;
            cnt   <= '0;
            pre   <= '0;
            mm    <= '0;
          end else if (cnt >= CNT_W'(RISE_TIMEOUT - 1)) begin
            state  <= ST_DONE;
            res_to <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_MEASURE: begin
          if (pre == PRE_W'(CYC_PER_MM - 1)) begin
            pre <= '0;
            if (mm != '1) mm <= mm + DIST_W'(1);
          end else begin
            pre <= pre + PRE_W'(1);
          end
          // A fall coinciding with the ECHO_MAX limit is reported as a valid range.
          if (fall_c) begin
            state  <= ST_DONE;
            res_to <= 1'b0;
          end else if (cnt == CNT_W'(ECHO_MAX - 1)) begin
            state  <= ST_DONE;
            res_to <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          bus.valid    <= 1'b1;
          bus.timeout  <= res_to;
          bus.distance <= res_to ? '1 : mm;
          state        <= ST_HOLDOFF;
          cnt          <= '0;
        end
        ST_HOLDOFF: begin
          if (cnt == CNT_W'(HOLDOFF - 1)) state <= ST_IDLE;
          else                            cnt   <= cnt + CNT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_supersonic_if.sv
// Directed bench for supersonic_if: trigger pulse, ranging, timeouts, holdoff and reset abort.
module tb_supersonic_if;

  logic clk;
  logic rst;
  logic echo_a, echo_b;
  logic trig_pin_a, trig_pin_b;
  int   errors = 0;
  int   checks = 0;

  supersonic_if_if bus_a ();
  supersonic_if_if bus_b ();

  supersonic_if #(
    .TRIG_CYCLES(500), .CYC_PER_MM(292), .RISE_TIMEOUT(1000), .ECHO_MAX(40000), .HOLDOFF(2000)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_a), .trig_pin(trig_pin_a), .echo_pin(echo_a)
  );

  // Second instance with a short ECHO_MAX for the over-long echo case.
  supersonic_if #(
    .TRIG_CYCLES(500), .CYC_PER_MM(292), .RISE_TIMEOUT(1000), .ECHO_MAX(5000), .HOLDOFF(2000)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .trig_pin(trig_pin_b), .echo_pin(echo_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Requests a measurement on dut and returns one cycle after TRIG falls (WAIT_RISE).
  task automatic run_to_wait_rise();
    int k;
    k = 0;
    bus_a.trigger = 1'b1;
    while (!bus_a.triggerSuc && k < 6000) begin
      tick(1);
      k++;
    end
    checks++;
    if (k >= 6000) begin
      errors++;
      $display("FAIL ack_wait: no triggerSuc within %0d cycles (required < 6000)", k);
    end
    bus_a.trigger = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.trigger = 1'b0;
    bus_b.trigger = 1'b0;
    echo_a = 1'b0;
    echo_b = 1'b0;
    tick(3);
    checks++;
    if (trig_pin_a !== 1'b0) begin errors++; $display("FAIL rst_trig_pin: got %b required 0", trig_pin_a); end
    checks++;
    if (bus_a.triggerSuc !== 1'b0) begin errors++; $display("FAIL rst_triggerSuc: got %b required 0", bus_a.triggerSuc); end
    checks++;
    if (bus_a.valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", bus_a.valid); end
    checks++;
    if (bus_a.timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b required 0", bus_a.timeout); end
    checks++;
    if (bus_a.distance !== 32'd0) begin errors++; $display("FAIL rst_distance: got %h required 0", bus_a.distance); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_trig_pulse();
    int   hi, suc_n;
    logic last_suc;
    hi = 0;
    suc_n = 0;
    last_suc = 1'b0;
    bus_a.trigger = 1'b1;
    tick(1);
    checks++;
    if (trig_pin_a !== 1'b1) begin errors++; $display("FAIL trig_rise: got %b required 1 one edge after trigger", trig_pin_a); end
    for (int i = 0; i < 1000 && trig_pin_a; i++) begin
      hi++;
      if (bus_a.triggerSuc) suc_n++;
      last_suc = bus_a.triggerSuc;
      if (i == 100) bus_a.trigger = 1'b0;
      tick(1);
    end
    checks++;
    if (hi != 500) begin errors++; $display("FAIL trig_width: got %0d required 500", hi); end
    checks++;
    if (suc_n != 1) begin errors++; $display("FAIL suc_count: got %0d required 1", suc_n); end
    checks++;
    if (last_suc !== 1'b1) begin errors++; $display("FAIL suc_position: got %b required 1 on last TRIG cycle", last_suc); end
  endtask

  task automatic test_rise_timeout();
    int k;
    k = 0;
    while (!bus_a.valid && k < 3000) begin
      tick(1);
      k++;
    end
    checks++;
    if (k != 1000) begin errors++; $display("FAIL rise_to_latency: got %0d required 1000", k); end
    checks++;
    if (bus_a.distance !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rise_to_distance: got %h required ffffffff", bus_a.distance); end
    checks++;
    if (bus_a.timeout !== 1'b1) begin errors++; $display("FAIL rise_to_flag: got %b required 1", bus_a.timeout); end
    tick(1);
    checks++;
    if (bus_a.valid !== 1'b0) begin errors++; $display("FAIL valid_one_cycle: got %b required 0", bus_a.valid); end
  endtask

  // Entered one cycle after a valid strobe; trigger held high through holdoff.
  task automatic test_holdoff();
    int k;
    k = 1;
    bus_a.trigger = 1'b1;
    while (!trig_pin_a && k < 5000) begin
      tick(1);
      k++;
    end
    checks++;
    if (k != 2001) begin errors++; $display("FAIL holdoff_gap: got %0d required 2001", k); end
  endtask

  task automatic test_distance(input int high_cycles, input logic [31:0] exp_mm);
    int k, vcount;
    vcount = 0;
    run_to_wait_rise();
    echo_a = 1'b1;
    for (int i = 0; i < high_cycles; i++) begin
      tick(1);
      if (bus_a.valid) vcount++;
    end
    echo_a = 1'b0;
    k = 0;
    while (!bus_a.valid && k < 100) begin
      tick(1);
      k++;
    end
    checks++;
    if (vcount != 0) begin errors++; $display("FAIL early_valid: got %0d strobes required 0", vcount); end
    checks++;
    if (k != 4) begin errors++; $display("FAIL valid_latency: got %0d required 4", k); end
    checks++;
    if (bus_a.distance !== exp_mm) begin errors++; $display("FAIL distance_%0d: got %0d required %0d", high_cycles, bus_a.distance, exp_mm); end
    checks++;
    if (bus_a.timeout !== 1'b0) begin errors++; $display("FAIL distance_timeout: got %b required 0", bus_a.timeout); end
  endtask

  task automatic test_reset_abort();
    int vcount;
    vcount = 0;
    run_to_wait_rise();
    echo_a = 1'b1;
    tick(100);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus_a.distance !== 32'd0) begin errors++; $display("FAIL abort_distance: got %h required 0", bus_a.distance); end
    checks++;
    if ({trig_pin_a, bus_a.valid, bus_a.triggerSuc, bus_a.timeout} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_outputs: got %b required 0000", {trig_pin_a, bus_a.valid, bus_a.triggerSuc, bus_a.timeout});
    end
    tick(2);
    echo_a = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus_a.valid) vcount++;
    end
    checks++;
    if (vcount != 0) begin errors++; $display("FAIL abort_valid: got %0d strobes required 0", vcount); end
  endtask

  task automatic test_stale_echo();
    int k;
    echo_a = 1'b1;
    run_to_wait_rise();
    tick(50);
    echo_a = 1'b0;
    tick(50);
    echo_a = 1'b1;
    tick(2920);
    echo_a = 1'b0;
    k = 0;
    while (!bus_a.valid && k < 100) begin
      tick(1);
      k++;
    end
    checks++;
    if (k != 4) begin errors++; $display("FAIL stale_latency: got %0d required 4", k); end
    checks++;
    if (bus_a.distance !== 32'd10) begin errors++; $display("FAIL stale_distance: got %0d required 10", bus_a.distance); end
    checks++;
    if (bus_a.timeout !== 1'b0) begin errors++; $display("FAIL stale_timeout: got %b required 0", bus_a.timeout); end
  endtask

  task automatic test_echo_max();
    int k;
    k = 0;
    bus_b.trigger = 1'b1;
    while (!bus_b.triggerSuc && k < 1000) begin
      tick(1);
      k++;
    end
    bus_b.trigger = 1'b0;
    tick(1);
    echo_b = 1'b1;
    k = 0;
    while (!bus_b.valid && k < 6000) begin
      tick(1);
      k++;
    end
    checks++;
    if (k < 5000 || k > 5010) begin errors++; $display("FAIL echo_max_latency: got %0d required 5000..5010", k); end
    checks++;
    if (bus_b.distance !== 32'hFFFF_FFFF) begin errors++; $display("FAIL echo_max_distance: got %h required ffffffff", bus_b.distance); end
    checks++;
    if (bus_b.timeout !== 1'b1) begin errors++; $display("FAIL echo_max_flag: got %b required 1", bus_b.timeout); end
    echo_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_trig_pulse();
    test_rise_timeout();
    test_holdoff();
    test_distance(29200, 32'd100);
    test_distance(29491, 32'd100);
    test_reset_abort();
    test_stale_echo();
    test_echo_max();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
